// File: rtl/life_grid_streamer.sv
// life_grid_streamer
// Captures a snapshot of the Game of Life grid into a shadow register and
// streams it out one row per valid/ready handshake. Each row is tagged with
// its index, start/end-of-frame markers, its own population and the running
// frame population. Every output is driven straight from a flop, so the sink's
// ready never reaches valid or the row data through logic.

module life_grid_streamer #(
    parameter  int M  = 16,
    parameter  int N  = 16,
    localparam int RW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(M + 1),
    localparam int FW = $clog2(M * N + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [N*M-1:0]   grid_i,
    input  logic             snap_i,
    input  logic             row_ready_i,
    output logic             row_valid_o,
    output logic [M-1:0]     row_data_o,
    output logic [RW-1:0]    row_idx_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic [CW-1:0]    row_pop_o,
    output logic [FW-1:0]    frame_pop_o,
    output logic             busy_o,
    output logic [7:0]       overrun_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    // Number of live cells in one row.
    function automatic logic [CW-1:0] row_popcount(input logic [M-1:0] row);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < M; i++) begin
            cnt = cnt + CW'(row[i]);
        end
        return cnt;
    endfunction

    // Pick row idx out of a row-major flattened grid.
    function automatic logic [M-1:0] row_select(input logic [N*M-1:0] grid,
                                                input logic [RW-1:0]  idx);
        logic [M-1:0] sel;
        sel = {M{1'b0}};
        for (int y = 0; y < N; y++) begin
            sel = (idx == RW'(y)) ? grid[y*M +: M] : sel;
        end
        return sel;
    endfunction

    // Core state
    state_t          state_r,   state_nxt_s;
    logic [N*M-1:0]  shadow_r,  shadow_nxt_s;
    logic [RW-1:0]   row_idx_r, row_idx_nxt_s;
    logic [FW-1:0]   acc_r,     acc_nxt_s;
    logic [7:0]      overrun_r, overrun_nxt_s;

    // Registered outputs
    logic            row_valid_r, row_valid_nxt_s;
    logic [M-1:0]    row_data_r,  row_data_nxt_s;
    logic            sof_r,       sof_nxt_s;
    logic            eof_r,       eof_nxt_s;
    logic [CW-1:0]   row_pop_r,   row_pop_nxt_s;
    logic [FW-1:0]   frame_pop_r, frame_pop_nxt_s;
    logic            busy_r,      busy_nxt_s;

    // Handshake qualifiers
    logic            handshake_s;
    logic            final_hs_s;
    logic            snap_accept_s;
    logic            snap_reject_s;

    assign handshake_s   = row_valid_r & row_ready_i;
    assign final_hs_s    = handshake_s & (row_idx_r == LAST_ROW);
    assign snap_accept_s = snap_i & ((state_r == IDLE) | final_hs_s);
    assign snap_reject_s = snap_i & (state_r == STREAM) & ~final_hs_s;

    // Next-state logic: frame capture, row advance and accumulation.
    always_comb begin
        state_nxt_s   = state_r;
        shadow_nxt_s  = shadow_r;
        row_idx_nxt_s = row_idx_r;
        acc_nxt_s     = acc_r;
        case (state_r)
            IDLE: begin
                if (snap_accept_s) begin
                    state_nxt_s   = STREAM;
                    shadow_nxt_s  = grid_i;
                    row_idx_nxt_s = {RW{1'b0}};
                    acc_nxt_s     = {FW{1'b0}};
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            STREAM: begin
                if (snap_accept_s) begin
                    // Final row consumed and a new snapshot taken: no gap.
                    state_nxt_s   = STREAM;
                    shadow_nxt_s  = grid_i;
                    row_idx_nxt_s = {RW{1'b0}};
                    acc_nxt_s     = {FW{1'b0}};
                end else if (final_hs_s) begin
                    // Keep the full-frame total visible while idle.
                    state_nxt_s   = IDLE;
                    row_idx_nxt_s = {RW{1'b0}};
                    acc_nxt_s     = acc_r + FW'(row_pop_r);
                end else if (handshake_s) begin
                    row_idx_nxt_s = row_idx_r + RW'(1);
                    acc_nxt_s     = acc_r + FW'(row_pop_r);
                end else begin
                    state_nxt_s   = STREAM;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                row_idx_nxt_s = {RW{1'b0}};
                acc_nxt_s     = {FW{1'b0}};
            end
        endcase
    end

    // Saturating count of snapshot requests that arrive mid-frame.
    always_comb begin
        overrun_nxt_s = overrun_r;
        if (snap_reject_s && (overrun_r != 8'hFF)) begin
            overrun_nxt_s = overrun_r + 8'd1;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Output values for the next cycle, derived from the next core state.
    always_comb begin
        row_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        row_data_nxt_s  = {M{1'b0}};
        sof_nxt_s       = 1'b0;
        eof_nxt_s       = 1'b0;
        if (state_nxt_s == STREAM) begin
            row_valid_nxt_s = 1'b1;
            busy_nxt_s      = 1'b1;
            row_data_nxt_s  = row_select(shadow_nxt_s, row_idx_nxt_s);
            sof_nxt_s       = (row_idx_nxt_s == {RW{1'b0}});
            eof_nxt_s       = (row_idx_nxt_s == LAST_ROW);
        end else begin
            row_valid_nxt_s = 1'b0;
            busy_nxt_s      = 1'b0;
            row_data_nxt_s  = {M{1'b0}};
            sof_nxt_s       = 1'b0;
            eof_nxt_s       = 1'b0;
        end
        row_pop_nxt_s = row_popcount(row_data_nxt_s);
        if (state_nxt_s == STREAM) begin
            frame_pop_nxt_s = acc_nxt_s + FW'(row_pop_nxt_s);
        end else begin
            frame_pop_nxt_s = acc_nxt_s;
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            shadow_r    <= {(N*M){1'b0}};
            row_idx_r   <= {RW{1'b0}};
            acc_r       <= {FW{1'b0}};
            overrun_r   <= 8'd0;
            row_valid_r <= 1'b0;
            row_data_r  <= {M{1'b0}};
            sof_r       <= 1'b0;
            eof_r       <= 1'b0;
            row_pop_r   <= {CW{1'b0}};
            frame_pop_r <= {FW{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shadow_r    <= shadow_nxt_s;
            row_idx_r   <= row_idx_nxt_s;
            acc_r       <= acc_nxt_s;
            overrun_r   <= overrun_nxt_s;
            row_valid_r <= row_valid_nxt_s;
            row_data_r  <= row_data_nxt_s;
            sof_r       <= sof_nxt_s;
            eof_r       <= eof_nxt_s;
            row_pop_r   <= row_pop_nxt_s;
            frame_pop_r <= frame_pop_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign row_valid_o = row_valid_r;
    assign row_data_o  = row_data_r;
    assign row_idx_o   = row_idx_r;
    assign sof_o       = sof_r;
    assign eof_o       = eof_r;
    assign row_pop_o   = row_pop_r;
    assign frame_pop_o = frame_pop_r;
    assign busy_o      = busy_r;
    assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_life_grid_streamer.sv
// Testbench for life_grid_streamer (M=4, N=4): directed scenarios plus random
// traffic, every cycle compared against a frame-level reference model.

module tb_life_grid_streamer;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int RW = 2;
    localparam int CW = 3;
    localparam int FW = 5;

    logic              clk_i       = 1'b0;
    logic              reset_n_i   = 1'b0;
    logic [N*M-1:0]    grid_i      = 16'h0000;
    logic              snap_i      = 1'b0;
    logic              row_ready_i = 1'b0;
    logic              row_valid_o;
    logic [M-1:0]      row_data_o;
    logic [RW-1:0]     row_idx_o;
    logic              sof_o;
    logic              eof_o;
    logic [CW-1:0]     row_pop_o;
    logic [FW-1:0]     frame_pop_o;
    logic              busy_o;
    logic [7:0]        overrun_o;

    life_grid_streamer #(.M(M), .N(N)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .grid_i      (grid_i),
        .snap_i      (snap_i),
        .row_ready_i (row_ready_i),
        .row_valid_o (row_valid_o),
        .row_data_o  (row_data_o),
        .row_idx_o   (row_idx_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .row_pop_o   (row_pop_o),
        .frame_pop_o (frame_pop_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model: a captured frame as a list of row values
    bit m_on;
    int m_rows[N];
    int m_idx;
    int m_acc;
    int m_over;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ones(input int v);
        int c;
        c = 0;
        for (int b = 0; b < M; b++) c += (v >> b) & 1;
        return c;
    endfunction

    task automatic model_reset();
        m_on   = 1'b0;
        m_idx  = 0;
        m_acc  = 0;
        m_over = 0;
        for (int y = 0; y < N; y++) m_rows[y] = 0;
    endtask

    // Apply one clock edge to the model using the current inputs.
    task automatic model_edge();
        bit hs, last;
        hs   = m_on && row_ready_i;
        last = hs && (m_idx == N - 1);
        if (hs) begin
            m_acc += ones(m_rows[m_idx]);
            m_idx++;
        end
        if (snap_i && (!m_on || last)) begin
            for (int y = 0; y < N; y++) m_rows[y] = int'((grid_i >> (y * M)) & 16'h000F);
            m_idx = 0;
            m_acc = 0;
            m_on  = 1'b1;
        end else begin
            if (snap_i && m_on) m_over = (m_over >= 255) ? 255 : m_over + 1;
            if (last) begin
                m_on  = 1'b0;
                m_idx = 0;
            end
        end
    endtask

    task automatic compare_all();
        int d;
        d = m_on ? m_rows[m_idx] : 0;
        check_val("valid",     32'(row_valid_o), 32'(m_on));
        check_val("busy",      32'(busy_o),      32'(m_on));
        check_val("data",      32'(row_data_o),  32'(d));
        check_val("idx",       32'(row_idx_o),   32'(m_on ? m_idx : 0));
        check_val("sof",       32'(sof_o),       32'(m_on && m_idx == 0));
        check_val("eof",       32'(eof_o),       32'(m_on && m_idx == N - 1));
        check_val("row_pop",   32'(row_pop_o),   32'(ones(d)));
        check_val("frame_pop", 32'(frame_pop_o), 32'(m_on ? m_acc + ones(d) : m_acc));
        check_val("overrun",   32'(overrun_o),   32'(m_over));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        compare_all();
    endtask

    // Async reset between edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        reset_n_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    int g_data[4];
    int g_pop[4];
    int g_fp[4];

    initial begin
        g_data[0] = 2; g_data[1] = 4; g_data[2] = 7; g_data[3] = 0;
        g_pop[0]  = 1; g_pop[1]  = 1; g_pop[2]  = 3; g_pop[3]  = 0;
        g_fp[0]   = 1; g_fp[1]   = 2; g_fp[2]   = 5; g_fp[3]   = 5;
        model_reset();

        // 1. reset, then idle with no snapshot
        do_reset();
        repeat (10) tick();

        // 2. glider with sink always ready
        grid_i = 16'h0742; row_ready_i = 1'b1; snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("g_data", 32'(row_data_o),  32'(g_data[i]));
            check_val("g_idx",  32'(row_idx_o),   32'(i));
            check_val("g_pop",  32'(row_pop_o),   32'(g_pop[i]));
            check_val("g_fp",   32'(frame_pop_o), 32'(g_fp[i]));
            tick();
        end
        check_val("g_busy_end", 32'(busy_o),      32'd0);
        check_val("g_fp_end",   32'(frame_pop_o), 32'd5);
        repeat (3) tick();
        check_val("g_fp_hold",  32'(frame_pop_o), 32'd5);

        // 3. backpressure while row 1 is presented
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        tick();
        row_ready_i = 1'b0;
        repeat (3) begin
            tick();
            check_val("bp_data", 32'(row_data_o),  32'd4);
            check_val("bp_idx",  32'(row_idx_o),   32'd1);
            check_val("bp_fp",   32'(frame_pop_o), 32'd2);
        end
        row_ready_i = 1'b1;
        tick();
        check_val("bp_next_idx", 32'(row_idx_o), 32'd2);
        repeat (3) tick();

        // 4. rejected snapshots mid-frame, then saturation
        snap_i = 1'b1;
        tick();
        grid_i = 16'hFFFF;
        tick();
        tick();
        snap_i = 1'b0;
        tick();
        check_val("ov_two",  32'(overrun_o),  32'd2);
        check_val("ov_row3", 32'(row_data_o), 32'd0);
        tick();
        grid_i = 16'h0742; row_ready_i = 1'b0; snap_i = 1'b1;
        repeat (301) tick();
        check_val("ov_sat", 32'(overrun_o), 32'd255);
        snap_i = 1'b0; row_ready_i = 1'b1;
        repeat (5) tick();

        // 5. back-to-back frames
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        repeat (3) tick();
        grid_i = 16'h000F; snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        check_val("b2b_idx",  32'(row_idx_o),  32'd0);
        check_val("b2b_data", 32'(row_data_o), 32'hF);
        check_val("b2b_pop",  32'(row_pop_o),  32'd4);
        check_val("b2b_sof",  32'(sof_o),      32'd1);
        check_val("b2b_busy", 32'(busy_o),     32'd1);
        repeat (5) tick();

        // 6. reset mid-frame at row 2, then a fresh frame
        grid_i = 16'h0742; snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        repeat (2) tick();
        do_reset();
        tick();
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        check_val("rs_idx", 32'(row_idx_o),   32'd0);
        check_val("rs_fp",  32'(frame_pop_o), 32'd1);
        repeat (5) tick();

        // Random traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            snap_i      = ($urandom_range(0, 5) == 0);
            row_ready_i = ($urandom_range(0, 3) != 0);
            grid_i      = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                snap_i = 1'b0;
                do_reset();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
